uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters, range 2..8.
REQ-002 Parameter TAG_ENABLE, default 1: when 1, each payload byte is preceded by a tag byte.
REQ-003 Parameter TAG_BASE, default 8'h30: tag byte = TAG_BASE + granted requester index (ASCII '0'..).
REQ-004 clk  input  1  system clock (100 MHz).
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 reqValid  input  NUM_REQ  per-requester byte-available flag.
REQ-007 reqData  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 reqReady  output  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-009 txMessage  output  8  byte presented to the UART transmitter.
REQ-010 txStart  output  1  transmit request to the UART transmitter.
REQ-011 txIdle  input  1  transmitter idle flag, from the slower UART clock domain.
REQ-012 grantId  output  $clog2(NUM_REQ)  index of the requester currently being served.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 txIdle SHALL pass through a 2-flop synchronizer (idleSync) before any use; raw txIdle never reaches FSM logic.
REQ-015 FSM states SHALL be IDLE, START, WAIT, with a phase flag (TAG or DATA).
REQ-016 IDLE: if any reqValid=1, grant the first requester with reqValid=1 searching upward from lastGrant+1 modulo NUM_REQ (round robin), then go to START.
REQ-017 Grant cycle: latch reqData of grant, pulse reqReady[grant]=1 for exactly one cycle, update lastGrant and grantId.
REQ-018 Grant cycle: phase=TAG with txMessage=TAG_BASE+grant when TAG_ENABLE=1; otherwise phase=DATA with txMessage=latched byte.
REQ-019 START: txStart=1 and held; on idleSync=0 (transmitter accepted), go to WAIT with txStart=0 on the same clock edge.
REQ-020 WAIT: on idleSync=1, if phase=TAG, set phase=DATA, load txMessage=latched byte, go to START; if phase=DATA, go to IDLE.
REQ-021 txMessage SHALL remain stable from entry into START until WAIT exits.
REQ-022 reqValid deasserting after the grant SHALL NOT affect the byte in flight; reqValid changes in START/WAIT are ignored.
REQ-023 At most one reqReady bit SHALL be high per cycle, and only in the grant cycle.
REQ-024 Simultaneous requests are served one frame each in round-robin order; a requester holding reqValid high continuously gets one byte per rotation.
REQ-025 A new grant SHALL NOT occur earlier than the cycle after the WAIT->IDLE transition.
REQ-026 Tag addition SHALL be 8-bit modulo 256.

Reset
REQ-027 reset=1 SHALL asynchronously force: state=IDLE, phase=TAG, txStart=0, reqReady=0, txMessage=8'h00, grantId=0, busy=0, lastGrant=NUM_REQ-1 (first grant goes to requester 0), both synchronizer flops=1.
REQ-028 reset asserted mid-frame SHALL abort the frame with no reqReady re-pulse; the aborted byte is dropped.
REQ-029 Release of reset SHALL be synchronous to clk (external reset synchronizer); the first grant is possible on the second clk edge after release.

Structure
REQ-030 State enum (IDLE/START/WAIT) and phase enum belong in shared package uart_pkg, together with TAG_BASE default.
REQ-031 Round-robin selection SHALL be a sub-module rr_picker (inputs: request vector, lastGrant; outputs: found, grant index), purely combinational.
REQ-032 The synchronizer is inline logic, not a sub-module.

Verification
REQ-033 Single request: reqValid=4'b0100, reqData lane2=8'h41, TAG_ENABLE=1 -> reqReady=4'b0100 for 1 cycle, txMessage=8'h32 then 8'h41, two txStart assertions, busy drops after second idle.
REQ-034 Contention: reqValid=4'b1111 held, lanes 8'hA0..8'hA3 -> grant order 0,1,2,3,0; tags 8'h30,8'h31,8'h32,8'h33.
REQ-035 TAG_ENABLE=0, transmitter model with idle low for 1042 uart ticks -> txMessage equals only the payload, one txStart per byte, txStart held until idleSync=0.
REQ-036 Slow acceptance: txIdle held 1 for 500 cycles after txStart -> txStart stays 1, txMessage stable, no further reqReady pulses.
REQ-037 Reset mid-WAIT during the DATA phase -> txStart=0, busy=0, and the next grant goes to requester 0.
REQ-038 Requester drops reqValid after grant: lane1 valid for 1 cycle only -> full frame for lane1 still sent, then IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM state, frame phase and tag default.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    typedef enum logic {
        PH_TAG,
        PH_DATA
    } phase_t;

    localparam logic [7:0] TAG_BASE_DEFAULT = 8'h30;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request searching upward from lastGrant+1.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] lastGrant,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] grant
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(lastGrant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler feeding a UART transmitter, with optional per-byte tag prefix.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter bit          TAG_ENABLE = 1'b1,
    parameter logic [7:0]  TAG_BASE   = TAG_BASE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         reqValid,
    input  logic [8*NUM_REQ-1:0]       reqData,
    output logic [NUM_REQ-1:0]         reqReady,
    output logic [7:0]                 txMessage,
    output logic                       txStart,
    input  logic                       txIdle,
    output logic [$clog2(NUM_REQ)-1:0] grantId,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t           state;
    phase_t           phase;
    logic [1:0]       idleSync;
    logic [IDX_W-1:0] lastGrant;
    logic [IDX_W-1:0] pickIdx;
    logic             pickFound;
    logic [7:0]       dataLatch;
    logic [7:0]       pickByte;
    logic             armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idleSync <= '1;
        end else begin
            idleSync <= {idleSync[0], txIdle};
        end
    end

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req      (reqValid),
        .lastGrant(lastGrant),
        .found    (pickFound),
        .grant    (pickIdx)
    );

    assign pickByte = reqData[{pickIdx, 3'b000} +: 8];

    // armed holds off granting on the first edge after reset release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= PH_TAG;
            txStart   <= 1'b0;
            reqReady  <= '0;
            txMessage <= '0;
            grantId   <= '0;
            busy      <= 1'b0;
            lastGrant <= IDX_W'(NUM_REQ - 1);
            dataLatch <= '0;
            armed     <= 1'b0;
        end else begin
            reqReady <= '0;
            armed    <= 1'b1;
            case (state)
                IDLE: begin
                    if (armed && pickFound) begin
                        dataLatch <= pickByte;
                        reqReady  <= NUM_REQ'(1) << pickIdx;
                        lastGrant <= pickIdx;
                        grantId   <= pickIdx;
                        if (TAG_ENABLE) begin
                            phase     <= PH_TAG;
                            txMessage <= TAG_BASE + 8'(pickIdx);
                        end else begin
                            phase     <= PH_DATA;
                            txMessage <= pickByte;
                        end
                        txStart <= 1'b1;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (!idleSync[1]) begin
                        txStart <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (idleSync[1]) begin
                        if (phase == PH_TAG) begin
                            phase     <= PH_DATA;
                            txMessage <= dataLatch;
                            txStart   <= 1'b1;
                            state     <= START;
                        end else begin
                            phase <= PH_TAG;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: tagged and untagged instances driven by simple transmitter models.
module tb_uart_tx_scheduler;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   reqValid = '0;
    logic [8*N-1:0] reqData = '0;

    logic [N-1:0] reqReady, reqReady0;
    logic [7:0]   txMessage, txMessage0;
    logic         txStart, txStart0;
    logic         txIdle, txIdle0;
    logic [1:0]   grantId, grantId0;
    logic         busy, busy0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(N), .TAG_ENABLE(1'b1), .TAG_BASE(8'h30)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqData(reqData),
        .reqReady(reqReady), .txMessage(txMessage), .txStart(txStart),
        .txIdle(txIdle), .grantId(grantId), .busy(busy)
    );

    uart_tx_scheduler #(.NUM_REQ(N), .TAG_ENABLE(1'b0), .TAG_BASE(8'h30)) dut0 (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqData(reqData),
        .reqReady(reqReady0), .txMessage(txMessage0), .txStart(txStart0),
        .txIdle(txIdle0), .grantId(grantId0), .busy(busy0)
    );

    int unsigned nTests = 0;
    int unsigned nFail  = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // transmitter models and monitor state
    int         holdCycles = 20;
    int         hold0 = 20;
    bit         modelOn = 1'b1;
    logic [7:0] sentQ[$];
    logic [7:0] sent0Q[$];
    int         grantQ[$];
    int         startHold = 0;
    int         startHold0 = 0;
    int         startRise = 0;
    int         startRise0 = 0;
    int         readyPulses = 0;
    bit         multiHot = 1'b0;
    bit         longPulse = 1'b0;

    initial begin : tx_model
        int  cnt;
        bit  measuring;
        cnt = 0;
        measuring = 1'b0;
        txIdle = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                txIdle = 1'b1;
                cnt = 0;
                measuring = 1'b0;
            end else if (txIdle) begin
                if (modelOn && txStart) begin
                    sentQ.push_back(txMessage);
                    txIdle = 1'b0;
                    cnt = holdCycles;
                    startHold = 0;
                    measuring = 1'b1;
                end
            end else begin
                if (measuring) begin
                    if (txStart) startHold++;
                    else measuring = 1'b0;
                end
                cnt--;
                if (cnt <= 0) txIdle = 1'b1;
            end
        end
    end

    initial begin : tx_model0
        int  cnt;
        bit  measuring;
        cnt = 0;
        measuring = 1'b0;
        txIdle0 = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                txIdle0 = 1'b1;
                cnt = 0;
                measuring = 1'b0;
            end else if (txIdle0) begin
                if (txStart0) begin
                    sent0Q.push_back(txMessage0);
                    txIdle0 = 1'b0;
                    cnt = hold0;
                    startHold0 = 0;
                    measuring = 1'b1;
                end
            end else begin
                if (measuring) begin
                    if (txStart0) startHold0++;
                    else measuring = 1'b0;
                end
                cnt--;
                if (cnt <= 0) txIdle0 = 1'b1;
            end
        end
    end

    initial begin : monitor
        logic         prevStart, prevStart0;
        logic [N-1:0] prevReady;
        prevStart = 1'b0;
        prevStart0 = 1'b0;
        prevReady = '0;
        forever begin
            @(negedge clk);
            if (reqReady != '0) begin
                readyPulses++;
                grantQ.push_back(int'(grantId));
                if (!$onehot(reqReady)) multiHot = 1'b1;
                if (prevReady != '0) longPulse = 1'b1;
            end
            if (txStart && !prevStart) startRise++;
            if (txStart0 && !prevStart0) startRise0++;
            prevStart = txStart;
            prevStart0 = txStart0;
            prevReady = reqReady;
        end
    end

    task automatic clear_logs();
        sentQ.delete();
        sent0Q.delete();
        grantQ.delete();
        readyPulses = 0;
        startRise = 0;
        startRise0 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reqValid = '0;
        repeat (2) @(negedge clk);
        clear_logs();
        holdCycles = 20;
        hold0 = 20;
        modelOn = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy && !busy0 && txIdle && txIdle0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) check_value({tag, "_idle_timeout"}, 0, 1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (reqReady != '0) seen = 1'b1;
        end
        if (!seen) check_value({tag, "_ready_timeout"}, 0, 1);
    endtask

    initial begin : stimulus
        int  pulses;
        bit  startLow;
        bit  msgMoved;

        // reset values and first-grant timing after release
        repeat (2) @(negedge clk);
        check_value("rst_txStart", txStart, 0);
        check_value("rst_reqReady", reqReady, 0);
        check_value("rst_txMessage", txMessage, 8'h00);
        check_value("rst_grantId", grantId, 0);
        check_value("rst_busy", busy, 0);
        reqData = {8'h00, 8'h00, 8'h9C, 8'h00};
        reqValid = 4'b0010;
        reset = 1'b0;
        @(negedge clk);
        check_value("grant_edge1", reqReady, 4'b0000);
        @(negedge clk);
        check_value("grant_edge2", reqReady, 4'b0010);
        check_value("grant_edge2_msg", txMessage, 8'h31);
        reqValid = '0;
        wait_idle("first", 2000);
        check_value("first_count", sentQ.size(), 2);
        if (sentQ.size() == 2) begin
            check_value("first_tag", sentQ[0], 8'h31);
            check_value("first_data", sentQ[1], 8'h9C);
        end

        // single request on lane 2
        do_reset();
        reqData = {8'h00, 8'h41, 8'h00, 8'h00};
        reqValid = 4'b0100;
        wait_ready("single", 50);
        reqValid = '0;
        check_value("single_ready", reqReady, 4'b0100);
        check_value("single_grantId", grantId, 2);
        check_value("single_tag_msg", txMessage, 8'h32);
        check_value("single_busy", busy, 1);
        @(negedge clk);
        check_value("single_ready_1cyc", reqReady, 4'b0000);
        wait_idle("single", 2000);
        check_value("single_count", sentQ.size(), 2);
        if (sentQ.size() == 2) begin
            check_value("single_b0", sentQ[0], 8'h32);
            check_value("single_b1", sentQ[1], 8'h41);
        end
        check_value("single_starts", startRise, 2);
        check_value("single_pulses", readyPulses, 1);
        check_value("single_busy_end", busy, 0);
        check_value("single_start_hold", startHold, 2);

        // contention: all four held
        do_reset();
        reqData = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        reqValid = 4'b1111;
        pulses = 0;
        for (int n = 0; n < 4000 && pulses < 5; n++) begin
            @(negedge clk);
            if (reqReady != '0) pulses++;
        end
        reqValid = '0;
        check_value("cont_pulses", pulses, 5);
        wait_idle("cont", 2000);
        check_value("cont_grants", grantQ.size(), 5);
        if (grantQ.size() == 5) begin
            check_value("cont_g0", grantQ[0], 0);
            check_value("cont_g1", grantQ[1], 1);
            check_value("cont_g2", grantQ[2], 2);
            check_value("cont_g3", grantQ[3], 3);
            check_value("cont_g4", grantQ[4], 0);
        end
        check_value("cont_bytes", sentQ.size(), 10);
        if (sentQ.size() == 10) begin
            check_value("cont_tag0", sentQ[0], 8'h30);
            check_value("cont_dat0", sentQ[1], 8'hA0);
            check_value("cont_tag1", sentQ[2], 8'h31);
            check_value("cont_dat1", sentQ[3], 8'hA1);
            check_value("cont_tag2", sentQ[4], 8'h32);
            check_value("cont_tag3", sentQ[6], 8'h33);
            check_value("cont_dat3", sentQ[7], 8'hA3);
            check_value("cont_tag4", sentQ[8], 8'h30);
        end

        // untagged instance with a slow transmitter
        do_reset();
        hold0 = 1042;
        reqData = {8'h5A, 8'h00, 8'hC7, 8'h00};
        reqValid = 4'b1010;
        pulses = 0;
        for (int n = 0; n < 5000 && pulses < 2; n++) begin
            @(negedge clk);
            if (reqReady0 != '0) pulses++;
        end
        reqValid = '0;
        check_value("notag_pulses", pulses, 2);
        wait_idle("notag", 3000);
        check_value("notag_count", sent0Q.size(), 2);
        if (sent0Q.size() == 2) begin
            check_value("notag_b0", sent0Q[0], 8'hC7);
            check_value("notag_b1", sent0Q[1], 8'h5A);
        end
        check_value("notag_starts", startRise0, 2);
        check_value("notag_start_hold", startHold0, 2);

        // slow acceptance: transmitter ignores txStart for 500 cycles
        do_reset();
        modelOn = 1'b0;
        reqData = {8'h00, 8'h00, 8'h00, 8'h77};
        reqValid = 4'b0001;
        wait_ready("slow", 50);
        reqValid = 4'b1111;
        startLow = 1'b0;
        msgMoved = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (!txStart) startLow = 1'b1;
            if (txMessage != 8'h30) msgMoved = 1'b1;
        end
        check_value("slow_start_held", startLow, 0);
        check_value("slow_msg_stable", msgMoved, 0);
        check_value("slow_pulses", readyPulses, 1);
        reqValid = '0;
        modelOn = 1'b1;
        wait_idle("slow", 2000);
        check_value("slow_count", sentQ.size(), 2);
        if (sentQ.size() == 2) check_value("slow_data", sentQ[1], 8'h77);

        // reset while waiting on the data byte
        do_reset();
        holdCycles = 200;
        reqData = {8'h00, 8'h55, 8'h00, 8'h00};
        reqValid = 4'b0100;
        wait_ready("rstmid", 50);
        reqValid = '0;
        for (int n = 0; n < 2000 && sentQ.size() < 2; n++) @(negedge clk);
        check_value("rstmid_data_sent", sentQ.size(), 2);
        repeat (10) @(negedge clk);
        check_value("rstmid_in_wait", txStart, 0);
        check_value("rstmid_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check_value("rstmid_txStart", txStart, 0);
        check_value("rstmid_busy", busy, 0);
        check_value("rstmid_msg", txMessage, 8'h00);
        repeat (2) @(negedge clk);
        check_value("rstmid_no_repulse", readyPulses, 1);
        holdCycles = 20;
        reqData = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        reqValid = 4'b1111;
        reset = 1'b0;
        wait_ready("rstmid_next", 50);
        reqValid = '0;
        check_value("rstmid_next_grant", grantId, 0);
        check_value("rstmid_next_ready", reqReady, 4'b0001);
        wait_idle("rstmid", 2000);

        // requester drops reqValid right after one cycle
        do_reset();
        reqData = {8'h00, 8'h00, 8'h9C, 8'h00};
        reqValid = 4'b0010;
        @(negedge clk);
        reqValid = '0;
        wait_idle("drop", 2000);
        check_value("drop_pulses", readyPulses, 1);
        check_value("drop_count", sentQ.size(), 2);
        if (sentQ.size() == 2) begin
            check_value("drop_tag", sentQ[0], 8'h31);
            check_value("drop_data", sentQ[1], 8'h9C);
        end
        check_value("drop_busy", busy, 0);

        check_value("ready_onehot", multiHot, 0);
        check_value("ready_one_cycle", longPulse, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
